leitor_display: RTL and testbench

LEITOR_DISPLAY -- requirements
Module: leitor_display

---
 rtl/leitor_display.sv | 220 ++++++++++++++++++++++
 tb/tb_leitor_display.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/leitor_display.sv
// Reads a multiplexed 4-digit 7-segment display (enables + shared segments)
// and rebuilds the shown value as a 16-bit frame with a valid/ready handshake.
module leitor_display #(
    parameter int STABLE_CYCLES = 4,
    parameter bit DIG_ACT_LOW   = 1'b1,
    parameter bit SEG_ACT_LOW   = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        D1,
    input  logic        D2,
    input  logic        D3,
    input  logic        D4,
    input  logic        a,
    input  logic        b,
    input  logic        c,
    input  logic        d,
    input  logic        e,
    input  logic        f,
    input  logic        g,
    output logic [15:0] valor,
    output logic        valido,
    input  logic        pronto,
    output logic        erro_seg,
    output logic        conflito,
    output logic        overrun
);

    localparam logic [7:0] STABLE_N = STABLE_CYCLES[7:0];

    typedef enum logic [1:0] {
        OCIOSO    = 2'd0,
        ESTAVEL   = 2'd1,
        CAPTURADO = 2'd2
    } state_t;

    state_t      r_state, w_state_next;
    logic [3:0]  r_sel;
    logic [6:0]  r_p;
    logic [1:0]  r_idx;
    logic [6:0]  r_lp;
    logic [7:0]  r_cnt;
    logic [3:0]  r_mask;
    logic [3:0]  r_slot [4];
    logic [3:0]  r_inv;
    logic        r_done;
    logic [15:0] r_valor;
    logic        r_valido;
    logic        r_erro;
    logic        r_conflito;
    logic        r_overrun;

    // sel[0] is D1 (leftmost); both buses normalised so 1 = active/lit
    logic [3:0]  w_sel_raw;
    logic [6:0]  w_p_raw;
    logic        w_onehot;
    logic        w_multi;
    logic [1:0]  w_sel_idx;
    logic [7:0]  w_cnt_inc;
    logic        w_load;
    logic        w_inc;
    logic        w_capture;
    logic        w_conf;
    logic [3:0]  w_nib;
    logic        w_inv;
    logic [3:0]  w_bit;
    logic [15:0] w_frame;

    assign w_sel_raw = {D4, D3, D2, D1} ^ {4{DIG_ACT_LOW}};
    assign w_p_raw   = {a, b, c, d, e, f, g} ^ {7{SEG_ACT_LOW}};
    assign w_onehot  = (r_sel != 4'd0) && ((r_sel & (r_sel - 4'd1)) == 4'd0);
    assign w_multi   = (r_sel != 4'd0) && !w_onehot;
    assign w_cnt_inc = r_cnt + 8'd1;
    assign w_bit     = 4'b0001 << r_idx;

    always_comb begin
        w_sel_idx = 2'd0;
        case (r_sel)
            4'b0010: w_sel_idx = 2'd1;
            4'b0100: w_sel_idx = 2'd2;
            4'b1000: w_sel_idx = 2'd3;
            default: w_sel_idx = 2'd0;
        endcase
    end

    always_comb begin
        w_nib = 4'hE;
        w_inv = 1'b0;
        case (r_lp)
            7'b1111110: w_nib = 4'h0;
            7'b0110000: w_nib = 4'h1;
            7'b1101101: w_nib = 4'h2;
            7'b1111001: w_nib = 4'h3;
            7'b0110011: w_nib = 4'h4;
            7'b1011011: w_nib = 4'h5;
            7'b1011111: w_nib = 4'h6;
            7'b1110000: w_nib = 4'h7;
            7'b1111111: w_nib = 4'h8;
            7'b1111011: w_nib = 4'h9;
            7'b0000000: w_nib = 4'hF;
            default: begin
                w_nib = 4'hE;
                w_inv = 1'b1;
            end
        endcase
    end

    // slot 0 (D1) lands in the top nibble
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_frame
            assign w_frame[15-4*gi -: 4] = r_slot[gi];
        end
    endgenerate

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_inc        = 1'b0;
        w_capture    = 1'b0;
        w_conf       = 1'b0;
        if (w_multi) begin
            w_conf       = 1'b1;
            w_state_next = OCIOSO;
        end else begin
            case (r_state)
                OCIOSO: begin
                    if (w_onehot) begin
                        w_load       = 1'b1;
                        w_state_next = ESTAVEL;
                    end
                end
                ESTAVEL: begin
                    if (!w_onehot) begin
                        w_state_next = OCIOSO;
                    end else if (w_sel_idx == r_idx && r_p == r_lp) begin
                        w_inc = 1'b1;
                        if (w_cnt_inc == STABLE_N) begin
                            w_capture    = 1'b1;
                            w_state_next = CAPTURADO;
                        end
                    end else begin
                        w_load = 1'b1;
                    end
                end
                CAPTURADO: begin
                    if (!w_onehot) begin
                        w_state_next = OCIOSO;
                    end else if (w_sel_idx != r_idx) begin
                        w_load       = 1'b1;
                        w_state_next = ESTAVEL;
                    end
                end
                default: w_state_next = OCIOSO;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= OCIOSO;
            r_sel      <= 4'd0;
            r_p        <= 7'd0;
            r_idx      <= 2'd0;
            r_lp       <= 7'd0;
            r_cnt      <= 8'd0;
            r_mask     <= 4'd0;
            r_inv      <= 4'd0;
            r_done     <= 1'b0;
            r_valor    <= 16'd0;
            r_valido   <= 1'b0;
            r_erro     <= 1'b0;
            r_conflito <= 1'b0;
            r_overrun  <= 1'b0;
            for (int i = 0; i < 4; i++) r_slot[i] <= 4'd0;
        end else begin
            r_sel   <= w_sel_raw;
            r_p     <= w_p_raw;
            r_state <= w_state_next;
            r_done  <= 1'b0;
            if (w_conf) r_conflito <= 1'b1;
            if (w_load) begin
                r_idx <= w_sel_idx;
                r_lp  <= r_p;
                r_cnt <= 8'd1;
            end else if (w_inc) begin
                r_cnt <= w_cnt_inc;
            end
            if (w_capture) begin
                r_slot[r_idx] <= w_nib;
                r_inv[r_idx]  <= w_inv;
                if ((r_mask | w_bit) == 4'hF) begin
                    r_mask <= 4'd0;
                    r_done <= 1'b1;
                end else begin
                    r_mask <= r_mask | w_bit;
                end
            end
            // slots cannot change in the cycle after a capture, so r_done sees a whole frame
            if (r_done) begin
                if (!r_valido || pronto) begin
                    r_valor  <= w_frame;
                    r_erro   <= |r_inv;
                    r_valido <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_valido && pronto) begin
                r_valido <= 1'b0;
            end
        end
    end

    assign valor    = r_valor;
    assign valido   = r_valido;
    assign erro_seg = r_erro;
    assign conflito = r_conflito;
    assign overrun  = r_overrun;

endmodule

// File: tb/tb_leitor_display.sv
// Bench for leitor_display: drives scanned display waveforms, checks frames
// through a scoreboard and flags/latency with per-scenario inline checks.
module tb_leitor_display;

    logic        clk = 1'b0;
    logic        rst;
    logic        D1, D2, D3, D4;
    logic        a, b, c, d, e, f, g;
    logic [15:0] valor;
    logic        valido;
    logic        pronto;
    logic        erro_seg;
    logic        conflito;
    logic        overrun;

    int n_tests = 0;
    int n_fail  = 0;
    int n_xfer  = 0;
    int n_vcyc  = 0;
    logic [16:0] sb[$];

    leitor_display dut (
        .clk(clk), .rst(rst),
        .D1(D1), .D2(D2), .D3(D3), .D4(D4),
        .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g),
        .valor(valor), .valido(valido), .pronto(pronto),
        .erro_seg(erro_seg), .conflito(conflito), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // scoreboard side: every accepted frame is checked against the oldest expectation
    always @(negedge clk) begin
        if (valido) n_vcyc++;
        if (!rst && valido && pronto) begin
            logic [16:0] exp_v;
            n_xfer++;
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL frame_unexpected got erro=%0b valor=%h, none expected", erro_seg, valor);
            end else begin
                exp_v = sb.pop_front();
                if ({erro_seg, valor} !== exp_v) begin
                    n_fail++;
                    $display("FAIL frame got erro=%0b valor=%h, want erro=%0b valor=%h",
                             erro_seg, valor, exp_v[16], exp_v[15:0]);
                end else begin
                    $display("[TB] frame erro=%0b valor=%h ok", erro_seg, valor);
                end
            end
        end
    end

    function automatic logic [6:0] seg(input int v);
        case (v)
            0: return 7'b1111110;
            1: return 7'b0110000;
            2: return 7'b1101101;
            3: return 7'b1111001;
            4: return 7'b0110011;
            5: return 7'b1011011;
            6: return 7'b1011111;
            7: return 7'b1110000;
            8: return 7'b1111111;
            9: return 7'b1111011;
            default: return 7'b0000000;
        endcase
    endfunction

    // en[3] = D1 ... en[0] = D4; both buses active low at default parameters
    task automatic set_in(input logic [3:0] en, input logic [6:0] p);
        {D1, D2, D3, D4} = ~en;
        {a, b, c, d, e, f, g} = ~p;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic hold(input logic [3:0] en, input logic [6:0] p, input int n);
        set_in(en, p);
        step(n);
    endtask

    task automatic scan4(input logic [6:0] p1, input logic [6:0] p2,
                         input logic [6:0] p3, input logic [6:0] p4, input int n);
        hold(4'b1000, p1, n);
        hold(4'b0100, p2, n);
        hold(4'b0010, p3, n);
        hold(4'b0001, p4, n);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_in(4'b0000, 7'd0);
        step(2);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        hold(4'b1000, seg(8), 3);
        rst = 1'b1;
        step(2);
        n_tests += 5;
        if (valor !== 16'd0)  begin n_fail++; $display("FAIL reset_valor got %h want 0000", valor); end
        if (valido !== 1'b0)  begin n_fail++; $display("FAIL reset_valido got %b want 0", valido); end
        if (erro_seg !== 1'b0) begin n_fail++; $display("FAIL reset_erro got %b want 0", erro_seg); end
        if (conflito !== 1'b0) begin n_fail++; $display("FAIL reset_conflito got %b want 0", conflito); end
        if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun got %b want 0", overrun); end
        $display("[TB] test_reset done");
        do_reset();
    endtask

    task automatic test_basic();
        int x0, v0, lat;
        do_reset();
        pronto = 1'b1;
        x0 = n_xfer; v0 = n_vcyc;
        sb.push_back({1'b0, 16'h1234});
        hold(4'b1000, seg(1), 8);
        hold(4'b0100, seg(2), 8);
        hold(4'b0010, seg(3), 8);
        set_in(4'b0001, seg(4));
        lat = 0;
        while (lat < 20 && valido !== 1'b1) begin
            step(1);
            lat++;
        end
        step(2);
        hold(4'b0000, 7'd0, 10);
        n_tests += 3;
        if (lat != 6) begin n_fail++; $display("FAIL basic_latency got %0d want 6", lat); end
        if (n_xfer - x0 != 1) begin n_fail++; $display("FAIL basic_xfers got %0d want 1", n_xfer - x0); end
        if (n_vcyc - v0 != 1) begin n_fail++; $display("FAIL basic_valido_cycles got %0d want 1", n_vcyc - v0); end
        $display("[TB] test_basic latency=%0d", lat);
    endtask

    task automatic test_unstable();
        int x0, v0;
        do_reset();
        pronto = 1'b1;
        x0 = n_xfer; v0 = n_vcyc;
        hold(4'b1000, seg(5), 8);
        hold(4'b0100, seg(6), 8);
        hold(4'b0010, seg(7), 8);
        hold(4'b0001, seg(8), 3);
        hold(4'b0000, 7'd0, 2);
        for (int k = 0; k < 4; k++) hold(4'b0001, (k % 2 == 0) ? seg(8) : seg(0), 2);
        hold(4'b0000, 7'd0, 6);
        n_tests++;
        if (n_vcyc != v0) begin n_fail++; $display("FAIL unstable_no_valido got %0d cycles want 0", n_vcyc - v0); end
        sb.push_back({1'b0, 16'h5679});
        hold(4'b0001, seg(9), 8);
        hold(4'b0000, 7'd0, 10);
        n_tests++;
        if (n_xfer - x0 != 1) begin n_fail++; $display("FAIL unstable_xfers got %0d want 1", n_xfer - x0); end
        $display("[TB] test_unstable done");
    endtask

    task automatic test_invalid();
        int x0;
        do_reset();
        pronto = 1'b1;
        x0 = n_xfer;
        sb.push_back({1'b1, 16'hFE34});
        sb.push_back({1'b0, 16'hF567});
        scan4(seg(15), 7'b1000001, seg(3), seg(4), 8);
        hold(4'b0000, 7'd0, 4);
        scan4(seg(15), seg(5), seg(6), seg(7), 8);
        hold(4'b0000, 7'd0, 10);
        n_tests++;
        if (n_xfer - x0 != 2) begin n_fail++; $display("FAIL invalid_xfers got %0d want 2", n_xfer - x0); end
        $display("[TB] test_invalid done");
    endtask

    task automatic test_conflict();
        int x0;
        do_reset();
        pronto = 1'b1;
        x0 = n_xfer;
        sb.push_back({1'b0, 16'h9123});
        hold(4'b1000, seg(9), 8);
        hold(4'b1010, seg(8), 1);
        hold(4'b0000, 7'd0, 2);
        n_tests++;
        if (conflito !== 1'b1) begin n_fail++; $display("FAIL conflict_set got %b want 1", conflito); end
        hold(4'b0100, seg(1), 8);
        hold(4'b0010, seg(2), 8);
        hold(4'b0001, seg(3), 8);
        hold(4'b0000, 7'd0, 10);
        n_tests += 2;
        if (conflito !== 1'b1) begin n_fail++; $display("FAIL conflict_sticky got %b want 1", conflito); end
        if (n_xfer - x0 != 1) begin n_fail++; $display("FAIL conflict_xfers got %0d want 1", n_xfer - x0); end
        $display("[TB] test_conflict done");
    endtask

    task automatic test_overrun();
        int x0;
        do_reset();
        pronto = 1'b0;
        x0 = n_xfer;
        scan4(seg(2), seg(4), seg(6), seg(8), 8);
        hold(4'b0000, 7'd0, 6);
        n_tests += 3;
        if (valido !== 1'b1) begin n_fail++; $display("FAIL overrun_first_valido got %b want 1", valido); end
        if (valor !== 16'h2468) begin n_fail++; $display("FAIL overrun_first_valor got %h want 2468", valor); end
        if (overrun !== 1'b0) begin n_fail++; $display("FAIL overrun_early got %b want 0", overrun); end
        scan4(seg(1), seg(3), seg(5), seg(7), 8);
        hold(4'b0000, 7'd0, 6);
        n_tests += 3;
        if (overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_flag got %b want 1", overrun); end
        if (valor !== 16'h2468) begin n_fail++; $display("FAIL overrun_hold_valor got %h want 2468", valor); end
        if (valido !== 1'b1) begin n_fail++; $display("FAIL overrun_hold_valido got %b want 1", valido); end
        sb.push_back({1'b0, 16'h2468});
        pronto = 1'b1;
        step(1);
        n_tests += 3;
        if (valido !== 1'b0) begin n_fail++; $display("FAIL overrun_valido_clear got %b want 0", valido); end
        if (overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_sticky got %b want 1", overrun); end
        if (n_xfer - x0 != 1) begin n_fail++; $display("FAIL overrun_xfers got %0d want 1", n_xfer - x0); end
        $display("[TB] test_overrun done");
    endtask

    task automatic test_reset_midframe();
        int x0;
        do_reset();
        pronto = 1'b1;
        hold(4'b1010, seg(0), 1);
        hold(4'b1000, seg(8), 8);
        hold(4'b0100, seg(9), 8);
        hold(4'b0000, 7'd0, 1);
        n_tests++;
        if (conflito !== 1'b1) begin n_fail++; $display("FAIL midrst_pre_conflito got %b want 1", conflito); end
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        n_tests += 4;
        if (valor !== 16'd0)  begin n_fail++; $display("FAIL midrst_valor got %h want 0000", valor); end
        if (valido !== 1'b0)  begin n_fail++; $display("FAIL midrst_valido got %b want 0", valido); end
        if (conflito !== 1'b0) begin n_fail++; $display("FAIL midrst_conflito got %b want 0", conflito); end
        if (overrun !== 1'b0) begin n_fail++; $display("FAIL midrst_overrun got %b want 0", overrun); end
        // D3/D4 first: a stale mask would complete a frame too early
        x0 = n_xfer;
        sb.push_back({1'b0, 16'h0517});
        hold(4'b0010, seg(1), 8);
        hold(4'b0001, seg(7), 8);
        hold(4'b1000, seg(0), 8);
        hold(4'b0100, seg(5), 8);
        hold(4'b0000, 7'd0, 10);
        n_tests++;
        if (n_xfer - x0 != 1) begin n_fail++; $display("FAIL midrst_xfers got %0d want 1", n_xfer - x0); end
        $display("[TB] test_reset_midframe done");
    endtask

    task automatic test_back_to_back();
        int x0;
        do_reset();
        pronto = 1'b1;
        x0 = n_xfer;
        sb.push_back({1'b0, 16'h4321});
        sb.push_back({1'b0, 16'h8765});
        scan4(seg(4), seg(3), seg(2), seg(1), 8);
        scan4(seg(8), seg(7), seg(6), seg(5), 8);
        hold(4'b0000, 7'd0, 10);
        n_tests++;
        if (n_xfer - x0 != 2) begin n_fail++; $display("FAIL b2b_xfers got %0d want 2", n_xfer - x0); end
        $display("[TB] test_back_to_back done");
    endtask

    initial begin
        rst = 1'b1;
        pronto = 1'b0;
        set_in(4'b0000, 7'd0);
        step(2);
        test_reset();
        test_basic();
        test_unstable();
        test_invalid();
        test_conflict();
        test_overrun();
        test_reset_midframe();
        test_back_to_back();
        n_tests++;
        if (sb.size() != 0) begin n_fail++; $display("FAIL scoreboard_leftover got %0d want 0", sb.size()); end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
